// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    // Word-length select encodings
    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Mask selecting the data bits actually transmitted for a word length
    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        logic [7:0] m;
        case (wls)
            WLS_5:   m = 8'h1F;
            WLS_6:   m = 8'h3F;
            WLS_7:   m = 8'h7F;
            WLS_8:   m = 8'hFF;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Parity bit for one character; mark (1) when parity is disabled.
module uart_tx_parity
    import uart_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic       par_c
);

    logic odd_ones;

    // Stick parity overrides; otherwise even/odd over the live data bits only
    always_comb begin
        odd_ones = ^(data & wls_mask(wls));
        if (!pen)
            par_c = 1'b1;
        else if (sp)
            par_c = ~eps;
        else
            par_c = eps ? odd_ones : ~odd_ones;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops the TX FIFO and shifts one framed character out on TXD.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BAUDCE,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_Q,
    output logic       FIFO_READ,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    output logic       TXD,
    output logic       TEMT
);

    localparam int unsigned TW = $clog2(2 * OVERSAMPLE);

    localparam logic [2:0] ST_IDLE   = 3'(TX_IDLE);
    localparam logic [2:0] ST_START  = 3'(TX_START);
    localparam logic [2:0] ST_DATA   = 3'(TX_DATA);
    localparam logic [2:0] ST_PARITY = 3'(TX_PARITY);
    localparam logic [2:0] ST_STOP   = 3'(TX_STOP);

    localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);

    logic [2:0]    state_q, state_n;
    logic [TW-1:0] tick_q, tick_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic [1:0]    wls_q, wls_n;
    logic          stb_q, stb_n;
    logic          pen_q, pen_n;
    logic          par_q, par_n;
    logic          line_n, rd_n, temt_n;
    logic          take, tick_end;
    logic [TW-1:0] tick_last;
    logic [2:0]    bit_last;
    logic          par_c;

    // Parity is computed from the FIFO head and current line control, captured at load
    uart_tx_parity u_parity (
        .data  (FIFO_Q),
        .wls   (WLS),
        .pen   (PEN),
        .eps   (EPS),
        .sp    (SP),
        .par_c (par_c)
    );

    // Next-state, counter and output decode
    always_comb begin
        state_n = state_q;
        tick_n  = tick_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        wls_n   = wls_q;
        stb_n   = stb_q;
        pen_n   = pen_q;
        par_n   = par_q;
        line_n  = 1'b1;
        rd_n    = 1'b0;
        take    = 1'b0;

        if (state_q == ST_STOP)
            tick_last = !stb_q ? BIT_LAST : ((wls_q == WLS_5) ? STOP15_LAST : STOP2_LAST);
        else
            tick_last = BIT_LAST;
        bit_last = 3'd4 + {1'b0, wls_q};
        tick_end = BAUDCE && (tick_q == tick_last);

        if (state_q != ST_IDLE && BAUDCE)
            tick_n = tick_end ? '0 : tick_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                take = !FIFO_EMPTY;
            end
            ST_START: begin
                line_n = 1'b0;
                if (tick_end) begin
                    state_n = ST_DATA;
                    line_n  = shift_q[0];
                end
            end
            ST_DATA: begin
                line_n = shift_q[0];
                if (tick_end) begin
                    shift_n = {1'b0, shift_q[7:1]};
                    if (bit_q == bit_last) begin
                        state_n = pen_q ? ST_PARITY : ST_STOP;
                        line_n  = pen_q ? par_q : 1'b1;
                    end else begin
                        bit_n  = bit_q + 3'd1;
                        line_n = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                line_n = par_q;
                if (tick_end) begin
                    state_n = ST_STOP;
                    line_n  = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick_end) begin
                    state_n = ST_IDLE;
                    // A queued character starts right after the last stop tick
                    take    = !FIFO_EMPTY;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (take) begin
            shift_n = FIFO_Q;
            wls_n   = WLS;
            stb_n   = STB;
            pen_n   = PEN;
            par_n   = par_c;
            bit_n   = 3'd0;
            tick_n  = '0;
            rd_n    = 1'b1;
            line_n  = 1'b0;
            state_n = ST_START;
        end

        temt_n = (state_n == ST_IDLE) && FIFO_EMPTY;
    end

    // State, datapath and registered outputs; break forces the line low
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            wls_q     <= WLS_5;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            TXD       <= 1'b1;
            FIFO_READ <= 1'b0;
            TEMT      <= 1'b1;
        end else begin
            state_q   <= state_n;
            tick_q    <= tick_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            wls_q     <= wls_n;
            stb_q     <= stb_n;
            pen_q     <= pen_n;
            par_q     <= par_n;
            TXD       <= BC ? 1'b0 : line_n;
            FIFO_READ <= rd_n;
            TEMT      <= temt_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (OVERSAMPLE = 16, BAUDCE every CLK).
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BAUDCE;
    logic       FIFO_EMPTY;
    logic [7:0] FIFO_Q;
    logic       FIFO_READ;
    logic [1:0] WLS;
    logic       STB, PEN, EPS, SP, BC;
    logic       TXD;
    logic       TEMT;

    int checks = 0;
    int errors = 0;

    // Small FIFO model: pushed by the stimulus, popped on FIFO_READ
    logic [7:0] mem [0:7];
    int wr = 0;
    int rd = 0;
    int cyc = 0;
    int rd_cyc = 0;
    int prev_rd_cyc = 0;
    int rd_save;

    assign FIFO_EMPTY = (rd == wr);
    assign FIFO_Q     = mem[rd[2:0]];

    always #5 CLK = ~CLK;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BAUDCE     (BAUDCE),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_Q     (FIFO_Q),
        .FIFO_READ  (FIFO_READ),
        .WLS        (WLS),
        .STB        (STB),
        .PEN        (PEN),
        .EPS        (EPS),
        .SP         (SP),
        .BC         (BC),
        .TXD        (TXD),
        .TEMT       (TEMT)
    );

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (FIFO_READ === 1'b1) begin
            rd          <= rd + 1;
            prev_rd_cyc <= rd_cyc;
            rd_cyc      <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line_for(input string tag, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk(tag, 32'(TXD), 32'(v));
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr[2:0]] = d;
        wr = wr + 1;
    endtask

    // Expect one complete frame starting at the sample after the load edge
    task automatic frame(input string tag, input logic [7:0] d, input int nbits,
                         input logic pen, input logic par, input int stop, input logic mess);
        @(negedge CLK);
        chk({tag, " start"}, 32'(TXD), 32'd0);
        chk({tag, " pop"}, 32'(FIFO_READ), 32'd1);
        if (mess) begin
            WLS = ~WLS; PEN = ~PEN; STB = ~STB; EPS = ~EPS; SP = ~SP;
        end
        line_for({tag, " start"}, 1'b0, OS - 1);
        for (int i = 0; i < nbits; i++)
            line_for({tag, " data"}, d[i], OS);
        if (pen)
            line_for({tag, " parity"}, par, OS);
        line_for({tag, " stop"}, 1'b1, stop - 1);
        @(negedge CLK);
        chk({tag, " stop end"}, 32'(TXD), 32'd1);
        chk({tag, " temt busy"}, 32'(TEMT), 32'd0);
    endtask

    task automatic send_char(input string tag, input logic [7:0] d, input int nbits,
                             input logic pen, input logic par, input int stop, input logic mess);
        @(negedge CLK);
        push(d);
        frame(tag, d, nbits, pen, par, stop, mess);
        @(negedge CLK);
        chk({tag, " temt"}, 32'(TEMT), 32'd1);
        chk({tag, " idle"}, 32'(TXD), 32'd1);
    endtask

    initial begin
        RST = 1'b1; BAUDCE = 1'b1; BC = 1'b0;
        WLS = 2'b11; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset txd", 32'(TXD), 32'd1);
        chk("reset rd", 32'(FIFO_READ), 32'd0);
        chk("reset temt", 32'(TEMT), 32'd1);
        RST = 1'b0;
        line_for("idle", 1'b1, 4);
        chk("idle no pop", 32'(rd), 32'd0);

        // 8N1 0x55
        send_char("8n1", 8'h55, 8, 1'b0, 1'b0, 16, 1'b0);
        chk("8n1 pops", 32'(rd), 32'd1);

        // 5 bits, even parity, 1.5 stop; line control scrambled after load
        WLS = 2'b00; PEN = 1'b1; EPS = 1'b1; STB = 1'b1; SP = 1'b0;
        send_char("5e15", 8'h13, 5, 1'b1, 1'b1, 24, 1'b1);

        // Stick parity, 7 bits
        WLS = 2'b10; PEN = 1'b1; SP = 1'b1; EPS = 1'b1; STB = 1'b0;
        send_char("stick eps1", 8'h7F, 7, 1'b1, 1'b0, 16, 1'b0);
        EPS = 1'b0;
        send_char("stick eps0", 8'h7F, 7, 1'b1, 1'b1, 16, 1'b0);

        // Back-to-back 8N2
        WLS = 2'b11; PEN = 1'b0; SP = 1'b0; EPS = 1'b0; STB = 1'b1;
        rd_save = rd;
        @(negedge CLK);
        push(8'hA5);
        push(8'h3C);
        frame("b2b0", 8'hA5, 8, 1'b0, 1'b0, 32, 1'b0);
        frame("b2b1", 8'h3C, 8, 1'b0, 1'b0, 32, 1'b0);
        @(negedge CLK);
        chk("b2b temt", 32'(TEMT), 32'd1);
        chk("b2b pops", 32'(rd - rd_save), 32'd2);
        chk("b2b pop gap", 32'(rd_cyc - prev_rd_cyc), 32'd176);

        // Break for 40 ticks during DATA
        STB = 1'b0;
        rd_save = rd;
        @(negedge CLK);
        push(8'hFF);
        line_for("bc start", 1'b0, 16);
        line_for("bc bit0", 1'b1, 16);
        BC = 1'b1;
        line_for("bc forced", 1'b0, 40);
        BC = 1'b0;
        line_for("bc restored", 1'b1, 87);
        @(negedge CLK);
        chk("bc stop end", 32'(TXD), 32'd1);
        chk("bc temt busy", 32'(TEMT), 32'd0);
        @(negedge CLK);
        chk("bc temt", 32'(TEMT), 32'd1);
        chk("bc pops", 32'(rd - rd_save), 32'd1);

        // Reset during the parity bit
        WLS = 2'b00; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
        @(negedge CLK);
        push(8'h00);
        line_for("rst start", 1'b0, 16);
        line_for("rst data", 1'b0, 80);
        line_for("rst parity", 1'b0, 4);
        rd_save = rd;
        RST = 1'b1;
        #1;
        chk("rst txd", 32'(TXD), 32'd1);
        chk("rst temt", 32'(TEMT), 32'd1);
        chk("rst rd", 32'(FIFO_READ), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        line_for("post rst", 1'b1, 40);
        chk("post rst temt", 32'(TEMT), 32'd1);
        chk("post rst pops", 32'(rd - rd_save), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
